// File: rtl/icmp_read.sv
// ICMP message word parser: captures the header fields and three payload words
// from a fixed 5-word stream, one word per clock, with no handshake.
module icmp_read (
    input  logic [31:0] inputmessage,
    input  logic        reset,
    input  logic        clock,
    output logic [7:0]  icmp_type,
    output logic [7:0]  icmp_code,
    output logic [15:0] checksum,
    output logic [31:0] unused,
    output logic [31:0] outputmessage1,
    output logic [31:0] outputmessage2,
    output logic [31:0] outputmessage3
);

    localparam int unsigned W_WORD = 32;
    localparam int unsigned W_BYTE = 8;
    localparam int unsigned W_CSUM = 16;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_REST = 3'd1,
        S_D1   = 3'd2,
        S_D2   = 3'd3,
        S_D3   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_ld_hdr;
    logic w_ld_rest;
    logic w_ld_d1;
    logic w_ld_d2;
    logic w_ld_d3;

    logic [W_BYTE-1:0] r_type;
    logic [W_BYTE-1:0] r_code;
    logic [W_CSUM-1:0] r_csum;
    logic [W_WORD-1:0] r_rest;
    logic [W_WORD-1:0] r_d1;
    logic [W_WORD-1:0] r_d2;
    logic [W_WORD-1:0] r_d3;

    // Word-position state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    // Unconditional advance; illegal encodings fall back to the header slot
    always_comb begin
        w_next    = S_HDR;
        w_ld_hdr  = 1'b0;
        w_ld_rest = 1'b0;
        w_ld_d1   = 1'b0;
        w_ld_d2   = 1'b0;
        w_ld_d3   = 1'b0;
        case (r_state)
            S_HDR: begin
                w_next   = S_REST;
                w_ld_hdr = 1'b1;
            end
            S_REST: begin
                w_next    = S_D1;
                w_ld_rest = 1'b1;
            end
            S_D1: begin
                w_next  = S_D2;
                w_ld_d1 = 1'b1;
            end
            S_D2: begin
                w_next  = S_D3;
                w_ld_d2 = 1'b1;
            end
            S_D3: begin
                w_next  = S_HDR;
                w_ld_d3 = 1'b1;
            end
            default: w_next = S_HDR;
        endcase
    end

    // Field capture: each register loads only in the slot that owns it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_type <= '0;
            r_code <= '0;
            r_csum <= '0;
            r_rest <= '0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_d3   <= '0;
        end else begin
            if (w_ld_hdr) begin
                r_type <= inputmessage[31:24];
                r_code <= inputmessage[23:16];
                r_csum <= inputmessage[15:0];
            end
            if (w_ld_rest) r_rest <= inputmessage;
            if (w_ld_d1)   r_d1   <= inputmessage;
            if (w_ld_d2)   r_d2   <= inputmessage;
            if (w_ld_d3)   r_d3   <= inputmessage;
        end
    end

    assign icmp_type      = r_type;
    assign icmp_code      = r_code;
    assign checksum       = r_csum;
    assign unused         = r_rest;
    assign outputmessage1 = r_d1;
    assign outputmessage2 = r_d2;
    assign outputmessage3 = r_d3;

endmodule

// File: tb/tb_icmp_read.sv
// Directed bench for icmp_read: reset, basic parse, field split, wrap-around,
// asynchronous mid-message reset and constant-input hold behaviour.
module tb_icmp_read;

    logic        clock;
    logic        reset;
    logic [31:0] inputmessage;
    logic [7:0]  icmp_type;
    logic [7:0]  icmp_code;
    logic [15:0] checksum;
    logic [31:0] unused;
    logic [31:0] outputmessage1;
    logic [31:0] outputmessage2;
    logic [31:0] outputmessage3;

    int nvec = 0;
    int nerr = 0;

    // Expected field values and the word slot the next edge will sample
    logic [7:0]  e_type;
    logic [7:0]  e_code;
    logic [15:0] e_csum;
    logic [31:0] e_rest;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic [31:0] e_d3;
    int          pos;

    icmp_read dut (
        .inputmessage   (inputmessage),
        .reset          (reset),
        .clock          (clock),
        .icmp_type      (icmp_type),
        .icmp_code      (icmp_code),
        .checksum       (checksum),
        .unused         (unused),
        .outputmessage1 (outputmessage1),
        .outputmessage2 (outputmessage2),
        .outputmessage3 (outputmessage3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        chk({step, ":icmp_type"},      32'(icmp_type),  32'(e_type));
        chk({step, ":icmp_code"},      32'(icmp_code),  32'(e_code));
        chk({step, ":checksum"},       32'(checksum),   32'(e_csum));
        chk({step, ":unused"},         unused,          e_rest);
        chk({step, ":outputmessage1"}, outputmessage1,  e_d1);
        chk({step, ":outputmessage2"}, outputmessage2,  e_d2);
        chk({step, ":outputmessage3"}, outputmessage3,  e_d3);
    endtask

    task automatic clear_exp();
        e_type = 8'h00;
        e_code = 8'h00;
        e_csum = 16'h0000;
        e_rest = 32'h0;
        e_d1   = 32'h0;
        e_d2   = 32'h0;
        e_d3   = 32'h0;
        pos    = 0;
    endtask

    // Drive one word, clock it in, update the expectation, then check all fields
    task automatic apply(input string step, input logic [31:0] word);
        inputmessage = word;
        @(posedge clock);
        #1;
        case (pos)
            0: begin
                e_type = word[31:24];
                e_code = word[23:16];
                e_csum = word[15:0];
            end
            1: e_rest = word;
            2: e_d1   = word;
            3: e_d2   = word;
            default: e_d3 = word;
        endcase
        pos = (pos + 1) % 5;
        check_all(step);
    endtask

    initial begin
        reset        = 1'b0;
        inputmessage = 32'hFFFF_FFFF;
        clear_exp();

        // Reset held for two clocks
        @(posedge clock);
        @(posedge clock);
        #1;
        check_all("reset");
        #2 reset = 1'b1;

        // Basic parse
        apply("basic_w0", 32'h0000_0032);
        apply("basic_w1", 32'h0000_0000);
        apply("basic_w2", 32'h00AB_AB32);
        apply("basic_w3", 32'h00AB_AB32);
        apply("basic_w4", 32'h00CA_A200);
        chk("basic_final_csum", 32'(checksum), 32'h0000_0032);
        chk("basic_final_d3", outputmessage3, 32'h00CA_A200);

        // Field split, others unchanged
        apply("split_w0", 32'h0B01_F4A5);
        chk("split_type_const", 32'(icmp_type), 32'h0000_000B);
        chk("split_d1_held", outputmessage1, 32'h00AB_AB32);
        apply("split_w1", 32'h1111_2222);
        apply("split_w2", 32'h3333_4444);
        apply("split_w3", 32'h5555_6666);
        apply("split_w4", 32'h7777_8888);

        // Wrap-around keeps previous payload
        apply("wrap_w0", 32'h0800_FFFF);
        chk("wrap_type_const", 32'(icmp_type), 32'h0000_0008);
        chk("wrap_csum_const", 32'(checksum), 32'h0000_FFFF);
        chk("wrap_d1_held", outputmessage1, 32'h3333_4444);
        chk("wrap_d3_held", outputmessage3, 32'h7777_8888);
        apply("wrap_w1", 32'hDEAD_BEEF);
        apply("wrap_w2", 32'hCAFE_F00D);

        // Asynchronous reset mid-message, away from any clock edge
        #2 reset = 1'b0;
        #1;
        clear_exp();
        check_all("midrst_async");
        inputmessage = 32'h9999_9999;
        @(posedge clock);
        @(posedge clock);
        #1;
        check_all("midrst_held");
        #2 reset = 1'b1;

        // First word after release is W0
        apply("post_w0", 32'h0102_0304);
        chk("post_code_const", 32'(icmp_code), 32'h0000_0002);
        apply("post_w1", 32'h1000_0001);
        apply("post_w2", 32'h2000_0002);
        apply("post_w3", 32'h3000_0003);
        apply("post_w4", 32'h4000_0004);

        // Constant input for ten clocks
        for (int i = 0; i < 10; i++) begin
            apply($sformatf("hold_%0d", i), 32'hA5A5_5A5A);
        end
        chk("hold_type_const", 32'(icmp_type), 32'h0000_00A5);
        chk("hold_d2_const", outputmessage2, 32'hA5A5_5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
